// File: rtl/alu_if.sv
// Operand/result bundle between the datapath and the ALU.
// The ALU_OVF_EN macro adds the sticky signed-overflow flag Ovf.
// Vectors use ascending ranges, so index 0 is the MSB.
interface alu_if;
    logic [0:31] A;
    logic [0:31] B;
    logic [0:2]  S;
    logic [0:31] O;
    logic        Zero;
`ifdef ALU_OVF_EN
    logic        Ovf;
`endif

    // The datapath drives the operands and the op code, then reads the results.
`ifdef ALU_OVF_EN
    modport master (output A, output B, output S, input O, input Zero, input Ovf);
    modport slave  (input A, input B, input S, output O, output Zero, output Ovf);
`else
    modport master (output A, output B, output S, input O, input Zero);
    modport slave  (input A, input B, input S, output O, output Zero);
`endif
endinterface

// File: rtl/alu.sv
// 32-bit registered integer ALU with MIPS-style 3-bit op codes.
// The ALU_OVF_EN macro adds a sticky signed-overflow flag (Ovf) for ADD and SUB.
// Result and Zero are registered together. Latency is 1 cycle, throughput is 1 op per cycle.
module alu (
    input  logic clk,
    input  logic rst_n,
    alu_if.slave bus
);

    localparam logic [2:0] OpAnd  = 3'b000;
    localparam logic [2:0] OpOr   = 3'b001;
    localparam logic [2:0] OpAdd  = 3'b010;
    localparam logic [2:0] OpXor  = 3'b011;
    localparam logic [2:0] OpNor  = 3'b100;
    localparam logic [2:0] OpSltu = 3'b101;
    localparam logic [2:0] OpSub  = 3'b110;
    localparam logic [2:0] OpSlt  = 3'b111;

    // Internal little-endian copies. The ascending port ranges keep the same numeric value.
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;

    assign a  = bus.A;
    assign b  = bus.B;
    assign op = bus.S;

    logic [31:0] sum;
    logic [32:0] diff;
    logic        carry_out;
    logic        ovf_add;
    logic        ovf_sub;
    logic        lt_signed;
    logic        lt_unsigned;

    logic [31:0] o_d;
    logic [31:0] o_q;
    logic        zero_d;
    logic        zero_q;

    // Adder, subtractor (A + ~B + 1) and the overflow and compare terms derived from them.
    always_comb begin
        sum         = a + b;
        diff        = {1'b0, a} + {1'b0, ~b} + 33'd1;
        carry_out   = diff[32];
        ovf_add     = (a[31] == b[31]) && (sum[31] != a[31]);
        ovf_sub     = (a[31] != b[31]) && (diff[31] != a[31]);
        // Sign of the difference, corrected by overflow, holds across the full signed range.
        lt_signed   = diff[31] ^ ovf_sub;
        // No carry out of A + ~B + 1 means a borrow occurred.
        lt_unsigned = ~carry_out;
    end

    // Result mux. Zero is taken from the next-state result, not from the stale register.
    always_comb begin
        o_d = 32'd0;
        unique case (op)
            OpAnd:   o_d = a & b;
            OpOr:    o_d = a | b;
            OpAdd:   o_d = sum;
            OpXor:   o_d = a ^ b;
            OpNor:   o_d = ~(a | b);
            OpSltu:  o_d = {31'd0, lt_unsigned};
            OpSub:   o_d = diff[31:0];
            OpSlt:   o_d = {31'd0, lt_signed};
            default: o_d = 32'd0;
        endcase
        zero_d = (o_d == 32'd0);
    end

    // Output registers. Reset clears the result and sets Zero, since a cleared result is zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_q    <= 32'd0;
            zero_q <= 1'b1;
        end else begin
            o_q    <= o_d;
            zero_q <= zero_d;
        end
    end

    assign bus.O    = o_q;
    assign bus.Zero = zero_q;

`ifdef ALU_OVF_EN
    logic ovf_d;
    logic ovf_q;

    // Ovf sets on a signed overflow from ADD or SUB and stays set until reset.
    always_comb begin
        ovf_d = ovf_q;
        if ((op == OpAdd && ovf_add) || (op == OpSub && ovf_sub)) begin
            ovf_d = 1'b1;
        end
    end

    // Sticky overflow register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.Ovf = ovf_q;
`else
    // Without the overflow flag, the ADD overflow term has no consumer.
    logic unused_ovf;
    assign unused_ovf = ovf_add;
`endif

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for alu. Define ALU_OVF_EN to also check Ovf.
module tb_alu;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;

    alu_if bus ();

    alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) passed = passed + 1;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Apply operands between edges, then sample 1 ns after the capturing edge.
    task automatic step(input logic [31:0] a, input logic [31:0] b, input logic [2:0] s);
        @(negedge clk);
        bus.A = a;
        bus.B = b;
        bus.S = s;
        @(posedge clk);
        #1;
    endtask

    initial begin
        passed = 0;
        total  = 0;
        rst_n  = 1'b0;
        bus.A  = 32'd5;
        bus.B  = 32'd7;
        bus.S  = 3'b010;

        // Reset is held across edges.
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_O", bus.O, 32'd0);
        check("reset_Zero", {31'd0, bus.Zero}, 32'd1);
`ifdef ALU_OVF_EN
        check("reset_Ovf", {31'd0, bus.Ovf}, 32'd0);
`endif

        // The first edge after release captures the pending inputs.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_O", bus.O, 32'd12);
        check("first_edge_Zero", {31'd0, bus.Zero}, 32'd0);

        // Nominal sequence
        step(32'd10, 32'd12, 3'b010);
        check("add_O", bus.O, 32'd22);
        check("add_Zero", {31'd0, bus.Zero}, 32'd0);
        step(32'd5, 32'd5, 3'b110);
        check("sub_eq_O", bus.O, 32'd0);
        check("sub_eq_Zero", {31'd0, bus.Zero}, 32'd1);
        step(32'd10, 32'd11, 3'b111);
        check("slt_small", bus.O, 32'd1);
        step(32'd10, 32'd11, 3'b000);
        check("and", bus.O, 32'd10);
        step(32'd10, 32'd11, 3'b001);
        check("or", bus.O, 32'd11);

        // An input change between edges must not reach the outputs.
        bus.A = 32'd99;
        #2;
        check("hold_between_edges", bus.O, 32'd11);

        // Signed vs unsigned compare
        step(32'hFFFF_FFFF, 32'd1, 3'b111);
        check("slt_neg1_lt_1", bus.O, 32'd1);
        step(32'hFFFF_FFFF, 32'd1, 3'b101);
        check("sltu_max_lt_1", bus.O, 32'd0);
        check("sltu_Zero", {31'd0, bus.Zero}, 32'd1);
        step(32'h8000_0000, 32'h7FFF_FFFF, 3'b111);
        check("slt_min_lt_max", bus.O, 32'd1);
        step(32'h7FFF_FFFF, 32'hFFFF_FFFF, 3'b111);
        check("slt_max_lt_neg1", bus.O, 32'd0);
        step(32'd1, 32'hFFFF_FFFF, 3'b101);
        check("sltu_1_lt_max", bus.O, 32'd1);
        step(32'd3, 32'd3, 3'b101);
        check("sltu_equal", bus.O, 32'd0);

        // Wrap-around without signed overflow
        step(32'hFFFF_FFFF, 32'd1, 3'b010);
        check("wrap_add_O", bus.O, 32'd0);
        check("wrap_add_Zero", {31'd0, bus.Zero}, 32'd1);
`ifdef ALU_OVF_EN
        check("wrap_add_Ovf", {31'd0, bus.Ovf}, 32'd0);
`endif
        step(32'd0, 32'd1, 3'b110);
        check("wrap_sub_O", bus.O, 32'hFFFF_FFFF);
`ifdef ALU_OVF_EN
        check("wrap_sub_Ovf", {31'd0, bus.Ovf}, 32'd0);
`endif

        // Logic ops
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b011);
        check("xor", bus.O, 32'h0FF0_0FF0);
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b100);
        check("nor", bus.O, 32'h000F_000F);

        // Signed overflow wraps the result and sets the sticky flag.
        step(32'h7FFF_FFFF, 32'd1, 3'b010);
        check("ovf_add_O", bus.O, 32'h8000_0000);
`ifdef ALU_OVF_EN
        check("ovf_add_Ovf", {31'd0, bus.Ovf}, 32'd1);
`endif
        step(32'hF0F0_F0F0, 32'hFF00_FF00, 3'b000);
        check("and_after_ovf", bus.O, 32'hF000_F000);
`ifdef ALU_OVF_EN
        check("ovf_sticky", {31'd0, bus.Ovf}, 32'd1);
`endif

        // Asynchronous reset in the middle of a cycle, with no clock edge
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_O", bus.O, 32'd0);
        check("async_reset_Zero", {31'd0, bus.Zero}, 32'd1);
`ifdef ALU_OVF_EN
        check("async_reset_Ovf", {31'd0, bus.Ovf}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Subtract overflow: most negative value minus 1
        step(32'h8000_0000, 32'd1, 3'b110);
        check("ovf_sub_O", bus.O, 32'h7FFF_FFFF);
`ifdef ALU_OVF_EN
        check("ovf_sub_Ovf", {31'd0, bus.Ovf}, 32'd1);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
